fc_layer: RTL and testbench



---
 rtl/fc_pkg.sv | 42 ++++
 rtl/fc_layer_if.sv | 31 +++
 rtl/fc_mac.sv | 52 +++++
 rtl/fc_layer.sv | 177 +++++++++++++++++
 tb/tb_fc_layer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// fc_pkg: shared types, widths and the round/saturate helper for fc_layer.
//   fc_state_e : controller states (IDLE, LOAD, DRAIN, WRITE, DONE)
//   DATA_W/FRAC_W : 4.16 signed data words
//   PROD_W : 8.32 product width, ACC_W : accumulator width
//   round_sat() : 8.32 accumulator -> rounded, saturated 4.16 word
package fc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      DRAIN,
      WRITE,
      DONE
   } fc_state_e;

   localparam int DATA_W = 20;
   localparam int FRAC_W = 16;
   localparam int PROD_W = 40;
   localparam int ACC_W  = 52;
   localparam int RES_W  = ACC_W - FRAC_W;

   localparam logic signed [ACC_W-1:0] RND_HALF = 52'sd32768;
   localparam logic signed [RES_W-1:0] SAT_MAX  = 36'sd524287;
   localparam logic signed [RES_W-1:0] SAT_MIN  = -36'sd524288;

   // Round half up (add 0.5 LSB, arithmetic shift) then clamp to the
   // signed 20-bit range.
   function automatic logic signed [DATA_W-1:0] round_sat(
      input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] rnd;
      logic signed [RES_W-1:0] r;
      rnd = acc + RND_HALF;
      r   = rnd[ACC_W-1:FRAC_W];
      if (r > SAT_MAX)
         return SAT_MAX[DATA_W-1:0];
      else if (r < SAT_MIN)
         return SAT_MIN[DATA_W-1:0];
      else
         return r[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/fc_layer_if.sv
// fc_layer_if: control handshake plus layer-2 read, weight read and output
// write buses of fc_layer.
//   master : the fc_layer side (drives busy/done, addresses, output write)
//   slave  : the environment side (drives start, cdata_rd, wdata)
interface fc_layer_if
   import fc_pkg::*;
#(
   parameter int WADDR_W = 14
);
   logic                     start;
   logic                     busy;
   logic                     done;
   logic                     crd;
   logic [11:0]              caddr_rd;
   logic signed [DATA_W-1:0] cdata_rd;
   logic [WADDR_W-1:0]       waddr;
   logic signed [DATA_W-1:0] wdata;
   logic                     owr;
   logic [2:0]               oaddr;
   logic signed [DATA_W-1:0] odata;

   modport master (
      input  start, cdata_rd, wdata,
      output busy, done, crd, caddr_rd, waddr, owr, oaddr, odata
   );

   modport slave (
      output start, cdata_rd, wdata,
      input  busy, done, crd, caddr_rd, waddr, owr, oaddr, odata
   );
endinterface

// File: rtl/fc_mac.sv
// fc_mac: two-stage multiply/accumulate datapath.
//   clk, reset   : clock, synchronous active-high reset
//   term_vld_i   : cdata_i/wdata_i carry a valid term this cycle
//   bias_sel_i   : the valid term is the bias (wdata_i only)
//   clr_i        : clear the accumulator at the end of this cycle
//   cdata_i      : 4.16 input feature
//   wdata_i      : 4.16 weight or bias
//   sum_o        : accumulator including the term currently in stage 1,
//                  i.e. the value the accumulator takes on the next edge
module fc_mac
   import fc_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     term_vld_i,
   input  logic                     bias_sel_i,
   input  logic                     clr_i,
   input  logic signed [DATA_W-1:0] cdata_i,
   input  logic signed [DATA_W-1:0] wdata_i,
   output logic signed [ACC_W-1:0]  sum_o
);
   logic signed [PROD_W-1:0] term_d, term_q;
   logic                     tvld_q;
   logic signed [ACC_W-1:0]  acc_d, acc_q;

   // Bias is aligned to the 8.32 product format by appending FRAC_W zeros.
   always_comb begin
      term_d = PROD_W'(cdata_i) * PROD_W'(wdata_i);
      if (bias_sel_i)
         term_d = PROD_W'($signed({wdata_i, {FRAC_W{1'b0}}}));
   end

   always_comb begin
      sum_o = acc_q;
      if (tvld_q)
         sum_o = acc_q + ACC_W'(term_q);
      acc_d = clr_i ? '0 : sum_o;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         term_q <= '0;
         tvld_q <= 1'b0;
         acc_q  <= '0;
      end else begin
         if (term_vld_i)
            term_q <= term_d;
         tvld_q <= term_vld_i;
         acc_q  <= acc_d;
      end
   end
endmodule

// File: rtl/fc_layer.sv
// fc_layer: fully-connected output stage. Streams N_IN layer-2 words per
// neuron against its weight row, adds the bias, rounds/saturates and writes
// N_OUT results, then pulses done.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fc_layer_if.master (start/busy/done, layer-2 read,
//                weight/bias read, output write); all outputs registered
// Build option: define FC_RELU_EN to clamp negative results to zero.
module fc_layer
   import fc_pkg::*;
#(
   parameter int N_IN    = 2048,
   parameter int N_OUT   = 4,
   parameter int WADDR_W = 14
)(
   input  logic       clk,
   input  logic       reset,
   fc_layer_if.master bus
);
   localparam int I_W       = $clog2(N_IN + 1);
   localparam int J_W       = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int BIAS_BASE = N_OUT * N_IN;
   localparam logic [I_W-1:0] I_BIAS = I_W'(N_IN);
   localparam logic [I_W-1:0] I_LAST = I_W'(N_IN - 1);
   localparam logic [J_W-1:0] J_LAST = J_W'(N_OUT - 1);

   fc_state_e state_d, state_q;
   logic [I_W-1:0] i_d, i_q;
   logic [J_W-1:0] j_d, j_q;
   logic           dcnt_d, dcnt_q;

   logic                     busy_d, busy_q;
   logic                     done_d, done_q;
   logic                     crd_d, crd_q;
   logic [11:0]              caddr_d, caddr_q;
   logic [WADDR_W-1:0]       waddr_d, waddr_q;
   logic                     owr_d, owr_q;
   logic [2:0]               oaddr_d, oaddr_q;
   logic signed [DATA_W-1:0] odata_d, odata_q;

   // Memory data returns one cycle after the address, so the term-valid and
   // bias flags are the LOAD state delayed by one cycle.
   logic rd_vld_q, bias_q;
   logic signed [ACC_W-1:0]  sum;
   logic signed [DATA_W-1:0] res;

   fc_mac u_mac (
      .clk        (clk),
      .reset      (reset),
      .term_vld_i (rd_vld_q),
      .bias_sel_i (bias_q),
      .clr_i      (state_q == WRITE),
      .cdata_i    (bus.cdata_rd),
      .wdata_i    (bus.wdata),
      .sum_o      (sum)
   );

   // The result is registered on the DRAIN->WRITE edge, the same edge the
   // bias lands in the accumulator, so it is taken from the adder output.
   always_comb begin
      res = round_sat(sum);
`ifdef FC_RELU_EN
      if (res[DATA_W-1])
         res = '0;
`endif
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      dcnt_d  = 1'b0;
      crd_d   = 1'b0;
      caddr_d = caddr_q;
      waddr_d = waddr_q;
      owr_d   = 1'b0;
      oaddr_d = oaddr_q;
      odata_d = odata_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = LOAD;
               i_d     = '0;
               j_d     = '0;
               crd_d   = 1'b1;
               caddr_d = '0;
               waddr_d = '0;
            end
         end
         LOAD: begin
            if (i_q == I_BIAS) begin
               state_d = DRAIN;
            end else begin
               i_d = i_q + 1'b1;
               if (i_q == I_LAST) begin
                  // bias fetch; caddr_rd keeps the last feature address
                  waddr_d = WADDR_W'(BIAS_BASE + int'(j_q));
               end else begin
                  crd_d   = 1'b1;
                  caddr_d = 12'(int'(i_q) + 1);
                  waddr_d = WADDR_W'(int'(j_q) * N_IN + int'(i_q) + 1);
               end
            end
         end
         DRAIN: begin
            if (dcnt_q) begin
               state_d = WRITE;
               owr_d   = 1'b1;
               oaddr_d = 3'(j_q);
               odata_d = res;
            end else begin
               dcnt_d = 1'b1;
            end
         end
         WRITE: begin
            if (j_q == J_LAST) begin
               state_d = DONE;
            end else begin
               state_d = LOAD;
               j_d     = j_q + 1'b1;
               i_d     = '0;
               crd_d   = 1'b1;
               caddr_d = '0;
               waddr_d = WADDR_W'((int'(j_q) + 1) * N_IN);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         i_q      <= '0;
         j_q      <= '0;
         dcnt_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         crd_q    <= 1'b0;
         caddr_q  <= '0;
         waddr_q  <= '0;
         owr_q    <= 1'b0;
         oaddr_q  <= '0;
         odata_q  <= '0;
         rd_vld_q <= 1'b0;
         bias_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         i_q      <= i_d;
         j_q      <= j_d;
         dcnt_q   <= dcnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         crd_q    <= crd_d;
         caddr_q  <= caddr_d;
         waddr_q  <= waddr_d;
         owr_q    <= owr_d;
         oaddr_q  <= oaddr_d;
         odata_q  <= odata_d;
         rd_vld_q <= (state_q == LOAD);
         bias_q   <= (state_q == LOAD) && (i_q == I_BIAS);
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.crd      = crd_q;
   assign bus.caddr_rd = caddr_q;
   assign bus.waddr    = waddr_q;
   assign bus.owr      = owr_q;
   assign bus.oaddr    = oaddr_q;
   assign bus.odata    = odata_q;
endmodule

// File: tb/tb_fc_layer.sv
`timescale 1ns/1ps
module tb_fc_layer;
   import fc_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_s, rst_l;

   fc_layer_if #(.WADDR_W(4))  s_bus ();
   fc_layer_if #(.WADDR_W(14)) l_bus ();

   fc_layer #(.N_IN(4), .N_OUT(2), .WADDR_W(4)) u_small (
      .clk   (clk),
      .reset (rst_s),
      .bus   (s_bus)
   );

   fc_layer #(.N_IN(2048), .N_OUT(4), .WADDR_W(14)) u_large (
      .clk   (clk),
      .reset (rst_l),
      .bus   (l_bus)
   );

   // small memories: 4 features, 8 weights at 0..7, biases at 8..9
   logic [19:0] cmem [0:3];
   logic [19:0] wmem [0:15];

   always @(posedge clk) begin
      if (s_bus.crd)
         s_bus.cdata_rd <= cmem[s_bus.caddr_rd[1:0]];
      s_bus.wdata <= wmem[s_bus.waddr];
   end

   // large memories: every feature 1.0, every weight 2^-11, bias j = j LSB
   always @(posedge clk) begin
      if (l_bus.crd)
         l_bus.cdata_rd <= 20'h10000;
      l_bus.wdata <= (l_bus.waddr < 14'd8192) ? 20'h00020
                                               : 20'(l_bus.waddr - 14'd8192);
   end

`ifdef FC_RELU_EN
   localparam logic [31:0] NEG_EXP = 32'h00000;
`else
   localparam logic [31:0] NEG_EXP = 32'hC0000;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_mem(input logic [19:0] d, input logic [19:0] w,
                           input logic [19:0] b);
      for (int k = 0; k < 4; k++) cmem[k] = d;
      for (int k = 0; k < 16; k++) wmem[k] = 20'h0;
      for (int k = 0; k < 8; k++) wmem[k] = w;
      wmem[8] = b;
      wmem[9] = b;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"},  32'(s_bus.busy), 0);
      chk({tag, "_done"},  32'(s_bus.done), 0);
      chk({tag, "_crd"},   32'(s_bus.crd), 0);
      chk({tag, "_caddr"}, 32'(s_bus.caddr_rd), 0);
      chk({tag, "_waddr"}, 32'(s_bus.waddr), 0);
      chk({tag, "_owr"},   32'(s_bus.owr), 0);
      chk({tag, "_oaddr"}, 32'(s_bus.oaddr), 0);
      chk({tag, "_odata"}, 32'($unsigned(s_bus.odata)), 0);
   endtask

   // One full small pass: owr at cycles 7 and 15, done at 16 after busy.
   task automatic run_small(input string tag, input logic [31:0] e0,
                            input logic [31:0] e1, input bit poke);
      int  cyc;
      int  nowr;
      bit  fin;
      s_bus.start = 1'b1;
      tick();
      s_bus.start = 1'b0;
      chk({tag, "_busy_rise"}, 32'(s_bus.busy), 1);
      chk({tag, "_first_crd"}, 32'(s_bus.crd), 1);
      cyc = 0; nowr = 0; fin = 1'b0;
      while (!fin && cyc < 40) begin
         s_bus.start = (poke && cyc == 3);
         if (s_bus.owr) begin
            chk({tag, "_owr_cyc"}, 32'(cyc), 32'(7 + 8 * nowr));
            chk({tag, "_oaddr"}, 32'(s_bus.oaddr), 32'(nowr));
            chk({tag, "_odata"}, 32'($unsigned(s_bus.odata)),
                (nowr == 0) ? e0 : e1);
            chk({tag, "_owr_vs_crd"}, 32'(s_bus.crd), 0);
            nowr++;
         end
         if (s_bus.done) begin
            chk({tag, "_done_cyc"}, 32'(cyc), 16);
            fin = 1'b1;
         end else begin
            tick();
            cyc++;
         end
      end
      s_bus.start = 1'b0;
      chk({tag, "_done_seen"}, 32'(fin), 1);
      chk({tag, "_owr_count"}, 32'(nowr), 2);
      tick();
      chk({tag, "_busy_fall"}, 32'(s_bus.busy), 0);
      chk({tag, "_done_pulse"}, 32'(s_bus.done), 0);
   endtask

   initial begin
      int cyc;
      int nowr;
      int last;
      int hits;
      bit fin;

      s_bus.start = 1'b0;
      l_bus.start = 1'b0;
      rst_s = 1'b1;
      rst_l = 1'b1;
      load_mem(20'h0, 20'h0, 20'h0);
      repeat (3) tick();
      rst_s = 1'b0;
      rst_l = 1'b0;
      tick();
      chk_zero("reset");

      load_mem(20'h0, 20'h0, 20'h01000);
      run_small("bias", 32'h01000, 32'h01000, 1'b0);

      load_mem(20'h10000, 20'h10000, 20'h0);
      run_small("unit", 32'h40000, 32'h40000, 1'b1);

      load_mem(20'h10000, 20'h30000, 20'h0);
      run_small("sat", 32'h7FFFF, 32'h7FFFF, 1'b0);

      load_mem(20'h10000, 20'hF0000, 20'h0);
      run_small("neg", NEG_EXP, NEG_EXP, 1'b0);

      // 0.5 LSB rounds to 1, 1.5 LSB rounds to 2
      load_mem(20'h0, 20'h0, 20'h0);
      cmem[2] = 20'h00001;
      wmem[2] = 20'h08000;
      wmem[6] = 20'h18000;
      run_small("round", 32'h00001, 32'h00002, 1'b0);

      // mid-run reset during the second neuron's LOAD
      load_mem(20'h10000, 20'h10000, 20'h0);
      s_bus.start = 1'b1;
      tick();
      s_bus.start = 1'b0;
      repeat (10) tick();
      rst_s = 1'b1;
      tick();
      rst_s = 1'b0;
      chk_zero("midrst");
      hits = 0;
      for (int k = 0; k < 20; k++) begin
         if (s_bus.owr || s_bus.done || s_bus.busy) hits++;
         tick();
      end
      chk("midrst_quiet", 32'(hits), 0);
      run_small("after_rst", 32'h40000, 32'h40000, 1'b0);

      // start coincident with reset is dropped
      rst_s = 1'b1;
      s_bus.start = 1'b1;
      tick();
      rst_s = 1'b0;
      s_bus.start = 1'b0;
      chk("rst_start_busy", 32'(s_bus.busy), 0);
      tick();
      chk("rst_start_busy2", 32'(s_bus.busy), 0);
      chk("rst_start_crd", 32'(s_bus.crd), 0);

      // default sizing: owr every 2052 cycles, done at 8208
      l_bus.start = 1'b1;
      tick();
      l_bus.start = 1'b0;
      chk("big_busy_rise", 32'(l_bus.busy), 1);
      cyc = 0; nowr = 0; last = 0; fin = 1'b0;
      while (!fin && cyc < 9000) begin
         if (l_bus.owr) begin
            if (nowr == 0)
               chk("big_owr_first", 32'(cyc), 2051);
            else
               chk("big_owr_gap", 32'(cyc - last), 2052);
            chk("big_oaddr", 32'(l_bus.oaddr), 32'(nowr));
            chk("big_odata", 32'($unsigned(l_bus.odata)), 32'(32'h10000 + nowr));
            last = cyc;
            nowr++;
         end
         if (l_bus.done) begin
            chk("big_done_cyc", 32'(cyc), 8208);
            fin = 1'b1;
         end else begin
            tick();
            cyc++;
         end
      end
      chk("big_done_seen", 32'(fin), 1);
      chk("big_owr_count", 32'(nowr), 4);
      tick();
      chk("big_busy_fall", 32'(l_bus.busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
